// File: rtl/ex_mem_pkg.sv
// EX/MEM shared constants: reset/write polarities and stall-vector indices.
package ex_mem_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam int STALL_W   = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam int CNT_W = 2;

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register; also parks the multi-cycle
// accumulate state (partial product and step count) while EX stalls.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int REG_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [STALL_W-1:0]   stall,
  input  logic [ADDR_W-1:0]    ex_wd,
  input  logic                 ex_wreg,
  input  logic [REG_W-1:0]     ex_wdata,
  input  logic [REG_W-1:0]     ex_hi,
  input  logic [REG_W-1:0]     ex_lo,
  input  logic                 ex_whilo,
  input  logic [2*REG_W-1:0]   hilo_temp_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic [ADDR_W-1:0]    mem_wd,
  output logic                 mem_wreg,
  output logic [REG_W-1:0]     mem_wdata,
  output logic [REG_W-1:0]     mem_hi,
  output logic [REG_W-1:0]     mem_lo,
  output logic                 mem_whilo,
  output logic [2*REG_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]     cnt_o
);

  logic [ADDR_W-1:0]  wd_q;
  logic               wreg_q;
  logic [REG_W-1:0]   wdata_q;
  logic [REG_W-1:0]   hi_q;
  logic [REG_W-1:0]   lo_q;
  logic               whilo_q;
  logic [2*REG_W-1:0] htmp_q;
  logic [CNT_W-1:0]   cnt_q;

  logic ex_stl;
  logic mem_stl;

  assign ex_stl  = stall[STALL_EX];
  assign mem_stl = stall[STALL_MEM];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      wd_q    <= '0;
      wreg_q  <= WRITE_DISABLE;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= WRITE_DISABLE;
      htmp_q  <= '0;
      cnt_q   <= '0;
    end else if (ex_stl && !mem_stl) begin
      // Bubble into MEM, but keep the accumulate state for EX's retry.
      wd_q    <= '0;
      wreg_q  <= WRITE_DISABLE;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= WRITE_DISABLE;
      htmp_q  <= hilo_temp_i;
      cnt_q   <= cnt_i;
    end else if (!ex_stl) begin
      wd_q    <= ex_wd;
      wreg_q  <= ex_wreg;
      wdata_q <= ex_wdata;
      hi_q    <= ex_hi;
      lo_q    <= ex_lo;
      whilo_q <= ex_whilo;
      htmp_q  <= '0;
      cnt_q   <= '0;
    end
  end

  assign mem_wd      = wd_q;
  assign mem_wreg    = wreg_q;
  assign mem_wdata   = wdata_q;
  assign mem_hi      = hi_q;
  assign mem_lo      = lo_q;
  assign mem_whilo   = whilo_q;
  assign hilo_temp_o = htmp_q;
  assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for the EX/MEM pipeline register.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic        ex_whilo;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem #(.REG_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] wdata,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input logic whilo, input logic [63:0] ht,
                         input logic [1:0] cnt);
    chk({tag, ".wd"}, 64'(mem_wd), 64'(wd));
    chk({tag, ".wreg"}, 64'(mem_wreg), 64'(wreg));
    chk({tag, ".wdata"}, 64'(mem_wdata), 64'(wdata));
    chk({tag, ".hi"}, 64'(mem_hi), 64'(hi));
    chk({tag, ".lo"}, 64'(mem_lo), 64'(lo));
    chk({tag, ".whilo"}, 64'(mem_whilo), 64'(whilo));
    chk({tag, ".htmp"}, hilo_temp_o, ht);
    chk({tag, ".cnt"}, 64'(cnt_o), 64'(cnt));
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] hi,
                        input logic [31:0] lo, input logic whilo,
                        input logic [63:0] ht, input logic [1:0] cnt);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
    hilo_temp_i = ht; cnt_i = cnt;
  endtask

  initial begin
    // reset with every input driven high
    rst = 1'b1; flush = 1'b1; stall = 6'h3f;
    set_ex('1, 1'b1, '1, '1, '1, 1'b1, '1, '1);
    tick();
    chk_all("rst1", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_all("rst2", 0, 0, 0, 0, 0, 0, 0, 0);

    // advance
    rst = 1'b0; flush = 1'b0; stall = 6'b0;
    set_ex(5, 1, 32'h12345678, 32'h11, 32'h22, 0, '1, 3);
    tick();
    chk_all("adv", 5, 1, 32'h12345678, 32'h11, 32'h22, 0, 0, 0);

    // bubble: writes suppressed, accumulate state captured
    stall = 6'b001111;
    set_ex(9, 1, 32'hDEADBEEF, 32'h33, 32'h44, 1,
           64'h0000_0001_0000_0002, 1);
    tick();
    chk_all("bub", 0, 0, 0, 0, 0, 0, 64'h0000_0001_0000_0002, 1);

    // load A5A5A5A5 then hold 3 edges
    stall = 6'b0;
    set_ex(7, 1, 32'hA5A5A5A5, 32'h5, 32'h6, 1, 64'h77, 2);
    tick();
    chk_all("ld", 7, 1, 32'hA5A5A5A5, 32'h5, 32'h6, 1, 0, 0);
    stall = 6'b011111;
    set_ex(1, 0, 32'h1, 32'h2, 32'h3, 0, 64'h99, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("hold%0d", i), 7, 1, 32'hA5A5A5A5,
              32'h5, 32'h6, 1, 0, 0);
    end

    // bubble to get cnt=1, hold keeps it, then flush while holding
    stall = 6'b001111;
    set_ex(3, 1, 32'h1234, 32'h1, 32'h2, 1, 64'hABCD_0000_1234, 1);
    tick();
    chk_all("bub2", 0, 0, 0, 0, 0, 0, 64'hABCD_0000_1234, 1);
    stall = 6'b011111;
    set_ex(3, 1, 32'h1234, 32'h1, 32'h2, 1, 64'h5555, 3);
    tick();
    chk_all("holdc", 0, 0, 0, 0, 0, 0, 64'hABCD_0000_1234, 1);
    stall = 6'b0;
    set_ex(4, 1, 32'hCAFE, 32'h8, 32'h9, 1, 64'h1, 2);
    tick();
    chk_all("nz", 4, 1, 32'hCAFE, 32'h8, 32'h9, 1, 0, 0);
    stall = 6'b001111;
    set_ex(4, 1, 32'hCAFE, 32'h8, 32'h9, 1, 64'hF0F0, 1);
    tick();
    stall = 6'b011111; flush = 1'b1;
    tick();
    chk_all("flush", 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;

    // illegal stall (EX go, MEM stall) behaves as advance
    stall = 6'b010000;
    set_ex(12, 1, 32'h0BAD_F00D, 32'hA, 32'hB, 1, 64'h3, 3);
    tick();
    chk_all("ill", 12, 1, 32'h0BAD_F00D, 32'hA, 32'hB, 1, 0, 0);

    // madd: first EX cycle stalls, second completes
    stall = 6'b001111;
    set_ex(0, 0, 0, 0, 0, 0, 64'h0000_0003_0000_0004, 1);
    tick();
    chk("madd1.cnt", 64'(cnt_o), 64'd1);
    chk("madd1.htmp", hilo_temp_o, 64'h0000_0003_0000_0004);
    chk("madd1.whilo", 64'(mem_whilo), 64'd0);
    stall = 6'b0;
    set_ex(0, 0, 0, 32'h1, 32'h2, 1, 64'h0, 0);
    tick();
    chk_all("madd2", 0, 0, 0, 32'h1, 32'h2, 1, 0, 0);

    // reset mid multi-cycle op abandons it
    stall = 6'b001111;
    set_ex(6, 1, 32'h6, 32'h6, 32'h6, 1, 64'h0000_0008_0000_0009, 1);
    tick();
    chk("mid.cnt", 64'(cnt_o), 64'd1);
    rst = 1'b1;
    tick();
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0, 0);

    // first edge after reset advances normally
    rst = 1'b0; stall = 6'b0;
    set_ex(31, 1, 32'hFFFF0000, 32'h10, 32'h20, 0, 64'h7, 2);
    tick();
    chk_all("post", 31, 1, 32'hFFFF0000, 32'h10, 32'h20, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
